// File: rtl/simplepiano_pkg.sv
// Shared types and default sizing for the piano voice/envelope datapath.
package simplepiano_pkg;

    localparam int unsigned VOICES_DEF = 4;
    localparam int unsigned ENV_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

endpackage

// File: rtl/env_gen.sv
// One voice's linear attack/release envelope: a four-state FSM plus a saturating
// amplitude register stepped by the shared prescaler ticks.
module env_gen
    import simplepiano_pkg::*;
#(
    parameter int unsigned ENV_W = ENV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_i,
    input  logic             atk_tick_i,
    input  logic             rel_tick_i,
    output logic [ENV_W-1:0] env_o,
    output logic             active_o
);

    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam logic [ENV_W-1:0] ENV_ONE = ENV_W'(1);

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            env_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            active_q <= (env_d != '0);
        end
    end

    // Gate edges are tested before ticks so a state change always wins and holds env.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            IDLE: begin
                if (gate_i) state_d = ATTACK;
            end
            ATTACK: begin
                if (!gate_i) begin
                    state_d = RELEASE;
                end else if (env_q == ENV_MAX) begin
                    state_d = SUSTAIN;
                end else if (atk_tick_i) begin
                    env_d = env_q + ENV_ONE;
                    if (env_q == ENV_MAX - ENV_ONE) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!gate_i) state_d = RELEASE;
            end
            RELEASE: begin
                if (gate_i) begin
                    state_d = ATTACK;
                end else if (env_q == '0) begin
                    state_d = IDLE;
                end else if (rel_tick_i) begin
                    env_d = env_q - ENV_ONE;
                    if (env_q == ENV_ONE) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                env_d   = '0;
            end
        endcase
    end

    assign env_o    = env_q;
    assign active_o = active_q;

endmodule

// File: rtl/voice_env_mixer.sv
// Per-voice envelopes, voice mix and PWM audio output for the piano tone generators.
// Prescaler, mixer and PWM counter share one time base so frames align with ticks.
module voice_env_mixer
    import simplepiano_pkg::*;
#(
    parameter  int unsigned VOICES      = VOICES_DEF,
    parameter  int unsigned ENV_W       = ENV_W_DEF,
    parameter  int unsigned ATTACK_DIV  = 256,
    parameter  int unsigned RELEASE_DIV = 1024,
    localparam int unsigned SUM_W       = ENV_W + $clog2(VOICES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [VOICES-1:0] note,
    input  logic [VOICES-1:0] gate,
    output logic              pwm_out,
    output logic [VOICES-1:0] active,
    output logic [SUM_W-1:0]  level,
    output logic              frame_start
);

    localparam int unsigned       PRE_W    = $clog2(RELEASE_DIV);
    localparam int unsigned       ATK_W    = $clog2(ATTACK_DIV);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [SUM_W-1:0]  PWM_ONE  = SUM_W'(1);
    localparam logic [SUM_W-1:0]  PWM_LAST = '1;

    logic [VOICES-1:0] note_q, gate_q;
    logic [PRE_W-1:0]  pre_q;
    logic              atk_tick, rel_tick;
    logic [ENV_W-1:0]  env [VOICES];
    logic [VOICES-1:0] active_w;
    logic [SUM_W-1:0]  sum_d, sum_q;
    logic [SUM_W-1:0]  pwm_cnt_q, level_q;
    logic              pwm_q, frame_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q <= '0;
            gate_q <= '0;
            pre_q  <= '0;
        end else begin
            note_q <= note;
            gate_q <= gate;
            pre_q  <= pre_q + PRE_ONE;
        end
    end

    assign rel_tick = &pre_q;
    assign atk_tick = &pre_q[ATK_W-1:0];

    for (genvar i = 0; i < VOICES; i++) begin : g_voice
        env_gen #(
            .ENV_W (ENV_W)
        ) u_env (
            .clk        (clk),
            .rst_n      (rst_n),
            .gate_i     (gate_q[i]),
            .atk_tick_i (atk_tick),
            .rel_tick_i (rel_tick),
            .env_o      (env[i]),
            .active_o   (active_w[i])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (note_q[i]) sum_d = sum_d + SUM_W'(env[i]);
        end
    end

    // level only reloads on the last count, so duty never changes mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q         <= '0;
            pwm_cnt_q     <= '0;
            level_q       <= '0;
            frame_start_q <= 1'b0;
            pwm_q         <= 1'b0;
        end else begin
            sum_q         <= sum_d;
            pwm_cnt_q     <= pwm_cnt_q + PWM_ONE;
            frame_start_q <= (pwm_cnt_q == '0);
            pwm_q         <= ena & (pwm_cnt_q < level_q);
            if (pwm_cnt_q == PWM_LAST) level_q <= sum_q;
        end
    end

    assign pwm_out     = pwm_q;
    assign active      = active_w;
    assign level       = level_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_voice_env_mixer.sv
// Directed bench for voice_env_mixer with short envelope dividers; timing is
// frame-aligned so every expected value is an exact cycle-level figure.
module tb_voice_env_mixer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] note;
    logic [3:0] gate;
    logic       pwm_out;
    logic [3:0] active;
    logic [7:0] level;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int hi;
    int n;

    voice_env_mixer #(
        .VOICES      (4),
        .ENV_W       (6),
        .ATTACK_DIV  (4),
        .RELEASE_DIV (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .note        (note),
        .gate        (gate),
        .pwm_out     (pwm_out),
        .active      (active),
        .level       (level),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where frame_start is high (bounded).
    task automatic next_fs(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 600);
        chk(tag, {31'd0, frame_start}, 32'd1);
    endtask

    // Sum pwm_out over one full frame starting at a frame_start negedge.
    task automatic count_frame(output int high);
        high = 0;
        repeat (256) begin
            high += (pwm_out === 1'b1) ? 1 : 0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        note  = 4'h0;
        gate  = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm",    {31'd0, pwm_out},     32'd0);
        chk("rst_active", {28'd0, active},      32'd0);
        chk("rst_level",  {24'd0, level},       32'd0);
        chk("rst_fs",     {31'd0, frame_start}, 32'd0);
        rst_n = 1'b1;

        // Idle: first cycle after reset starts a frame, frames are 256 cycles
        @(negedge clk);
        chk("idle_first_fs", {31'd0, frame_start}, 32'd1);
        count_frame(hi);
        chk("idle_high",   hi,                       32'd0);
        chk("idle_level",  {24'd0, level},           32'd0);
        chk("idle_period", {31'd0, frame_start},     32'd1);

        // Voice 0 attack, gated at a frame start
        gate = 4'b0001;
        note = 4'b0001;
        @(negedge clk);
        chk("atk_act_1", {28'd0, active}, 32'd0);
        @(negedge clk);
        chk("atk_act_2", {28'd0, active}, 32'd0);
        @(negedge clk);
        chk("atk_act_3", {28'd0, active}, 32'd1);
        next_fs("fs_atk");
        chk("atk_level", {24'd0, level}, 32'd63);
        count_frame(hi);
        chk("atk_high", hi, 32'd63);

        // ena low for one frame during sustain
        chk("ena_pre_pwm", {31'd0, pwm_out}, 32'd1);
        ena = 1'b0;
        @(negedge clk);
        chk("ena_off_next", {31'd0, pwm_out}, 32'd0);
        hi = 0;
        repeat (254) begin
            hi += (pwm_out === 1'b1) ? 1 : 0;
            @(negedge clk);
        end
        chk("ena_off_high", hi, 32'd0);
        ena = 1'b1;
        @(negedge clk);
        chk("ena_fs_kept", {31'd0, frame_start}, 32'd1);
        chk("ena_level",   {24'd0, level},       32'd63);
        count_frame(hi);
        chk("ena_resume_high", hi, 32'd63);

        // All voices gated with notes high
        gate = 4'hF;
        note = 4'hF;
        next_fs("fs_all");
        chk("all_level",  {24'd0, level},  32'd252);
        chk("all_active", {28'd0, active}, 32'd15);
        count_frame(hi);
        chk("all_high", hi, 32'd252);

        // Silence voice 2's tone; its envelope keeps running
        note = 4'b1011;
        next_fs("fs_note2");
        chk("note2_level",  {24'd0, level},  32'd189);
        chk("note2_active", {28'd0, active}, 32'd15);
        count_frame(hi);
        chk("note2_high", hi, 32'd189);

        // Release voice 0 (only its tone reaches the mix), then retrigger at env=20
        gate = 4'b1110;
        note = 4'b0001;
        next_fs("fs_rel1");
        chk("rel_level1", {24'd0, level}, 32'd48);
        next_fs("fs_rel2");
        chk("rel_level2",  {24'd0, level},  32'd32);
        chk("rel_active2", {28'd0, active}, 32'd15);
        repeat (178) @(negedge clk);
        gate = 4'hF;
        next_fs("fs_retrig");
        chk("retrig_level",  {24'd0, level},  32'd38);
        chk("retrig_active", {28'd0, active}, 32'd15);
        next_fs("fs_resust");
        chk("resust_level", {24'd0, level}, 32'd63);

        // Full release of voice 0 from sustain down to idle
        gate = 4'b1110;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (active[0] === 1'b1 && n < 1100);
        chk("rel_cycles", n, 32'd1007);
        chk("rel_active", {28'd0, active}, 32'd14);
        repeat (200) @(negedge clk);
        chk("rel_floor_active", {28'd0, active}, 32'd14);

        // Mid-frame asynchronous reset with level 252
        next_fs("fs_prerst");
        gate = 4'hF;
        note = 4'hF;
        next_fs("fs_full");
        chk("full_level", {24'd0, level}, 32'd252);
        repeat (100) @(negedge clk);
        chk("mid_pwm", {31'd0, pwm_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pwm",    {31'd0, pwm_out},     32'd0);
        chk("arst_active", {28'd0, active},      32'd0);
        chk("arst_level",  {24'd0, level},       32'd0);
        chk("arst_fs",     {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_fs",    {31'd0, frame_start}, 32'd1);
        chk("post_rst_level", {24'd0, level},       32'd0);
        count_frame(hi);
        chk("post_rst_high", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
